// File: rtl/sync_emb_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sync_emb_decoder
// Purpose  : Embedded-sync (BT.656/BT.1120-style) decoder: finds preamble+XY,
//            tracks lines/fields and emits pixel-valid strobe and counters.
// Revision : 1.0 - initial release
// ============================================================================
module sync_emb_decoder #(
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 12,
    parameter int ACT_W      = 1920,
    parameter int ACT_H      = 1080,
    parameter int H_OFFSET   = 0,
    parameter int V_SKIP     = 24,
    parameter int INTERLACED = 0
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] pdata,
    output logic              hsync,
    output logic              vsync,
    output logic              field,
    output logic [CNT_W-1:0]  colcnt,
    output logic [CNT_W-1:0]  rowcnt,
    output logic              len_err,
    output logic              sync_err
);

    localparam logic [DATA_W-1:0] c_ones      = {DATA_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_col_last  = CNT_W'(ACT_W - 1);
    localparam logic [CNT_W-1:0]  c_skip_last = (H_OFFSET > 0) ? CNT_W'(H_OFFSET - 1) : '0;
    localparam logic [CNT_W-1:0]  c_vstart    = CNT_W'(V_SKIP);
    localparam logic [CNT_W-1:0]  c_vend      = CNT_W'(V_SKIP + ACT_H);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SKIP   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TAIL   = 2'd3
    } line_state_t;

    line_state_t       state_q, state_d;
    logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [DATA_W-1:0] pdata_q, pdata_d;
    logic              frame_seen_q, frame_seen_d;
    logic [CNT_W-1:0]  vline_q, vline_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  colcnt_q, colcnt_d;
    logic [CNT_W-1:0]  rowcnt_q, rowcnt_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic              field_q, field_d;
    logic              len_err_q, len_err_d;
    logic              sync_err_q, sync_err_d;

    logic w_preamble;
    logic w_xy;
    logic w_bad_xy;
    logic w_f;
    logic w_v;
    logic w_h;
    logic w_sav;
    logic w_eav;
    logic w_out_line;

    always_comb begin
        w_preamble = (d3_q == c_ones) && (d2_q == '0) && (d1_q == '0);
        w_xy       = w_preamble && datain[DATA_W-1];
        w_bad_xy   = w_preamble && !datain[DATA_W-1];
        w_f        = datain[DATA_W-2];
        w_v        = datain[DATA_W-3];
        w_h        = datain[DATA_W-4];
        w_sav      = w_xy && !w_h;
        w_eav      = w_xy && w_h;
        w_out_line = frame_seen_q && (vline_q >= c_vstart) && (vline_q < c_vend);
    end

    always_comb begin
        state_d      = state_q;
        d1_d         = datain;
        d2_d         = d1_q;
        d3_d         = d2_q;
        pdata_d      = datain;
        frame_seen_d = frame_seen_q;
        vline_d      = vline_q;
        word_cnt_d   = word_cnt_q;
        colcnt_d     = '0;
        rowcnt_d     = rowcnt_q;
        hsync_d      = 1'b0;
        vsync_d      = 1'b0;
        field_d      = field_q;
        len_err_d    = 1'b0;
        sync_err_d   = w_bad_xy;

        if (w_xy && w_v) begin
            vline_d      = '0;
            frame_seen_d = 1'b1;
        end
        if (w_sav && !w_v && (vline_q != c_cnt_max)) begin
            vline_d = vline_q + 1'b1;
        end

        if (w_sav) begin
            // A SAV outside IDLE means the previous line never saw its EAV.
            if (state_q != ST_IDLE) begin
                len_err_d = 1'b1;
            end
            if (!w_v && w_out_line) begin
                state_d    = (H_OFFSET > 0) ? ST_SKIP : ST_ACTIVE;
                word_cnt_d = '0;
                if (vline_q == c_vstart) begin
                    vsync_d  = 1'b1;
                    rowcnt_d = '0;
                    field_d  = (INTERLACED != 0) ? w_f : 1'b0;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else if (w_eav) begin
            if ((state_q == ST_SKIP) || (state_q == ST_ACTIVE)) begin
                len_err_d = 1'b1;
            end
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                if (rowcnt_q != c_cnt_max) begin
                    rowcnt_d = rowcnt_q + 1'b1;
                end
            end
        end else begin
            case (state_q)
                ST_SKIP: begin
                    if (word_cnt_q == c_skip_last) begin
                        state_d    = ST_ACTIVE;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    hsync_d  = 1'b1;
                    colcnt_d = word_cnt_q;
                    if (word_cnt_q == c_col_last) begin
                        state_d    = ST_TAIL;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            d1_q         <= '0;
            d2_q         <= '0;
            d3_q         <= '0;
            pdata_q      <= '0;
            frame_seen_q <= 1'b0;
            vline_q      <= '0;
            word_cnt_q   <= '0;
            colcnt_q     <= '0;
            rowcnt_q     <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            field_q      <= 1'b0;
            len_err_q    <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            d3_q         <= d3_d;
            pdata_q      <= pdata_d;
            frame_seen_q <= frame_seen_d;
            vline_q      <= vline_d;
            word_cnt_q   <= word_cnt_d;
            colcnt_q     <= colcnt_d;
            rowcnt_q     <= rowcnt_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            field_q      <= field_d;
            len_err_q    <= len_err_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign pdata    = pdata_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign field    = field_q;
    assign colcnt   = colcnt_q;
    assign rowcnt   = rowcnt_q;
    assign len_err  = len_err_q;
    assign sync_err = sync_err_q;

endmodule
`default_nettype wire
